note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_scheduler.sv | 109 ++++++++++
 tb/tb_note_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// Note scheduler: walks the note ROM and issues each note to its string
// once song_time comes within LOOKAHEAD of the note's play time.
module note_scheduler #(
    parameter logic [15:0] LOOKAHEAD = 16'd2000,
    parameter int          ADDR_W    = 12
) (
    input  logic              clk65,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic [15:0]       song_time,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [29:0]       fret,
    output logic [15:0]       fret_time,
    output logic [5:0]        fret_en,
    output logic              done,
    output logic [15:0]       note_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        ISSUE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       song_time_q;

    logic [15:0] note_time;
    logic [2:0]  note_str;
    logic [4:0]  note_fret;
    logic [16:0] deadline;
    logic        due;
    logic        rewind;

    assign note_time = rom_data[23:8];
    assign note_str  = rom_data[7:5];
    assign note_fret = rom_data[4:0];
    assign deadline  = {1'b0, song_time} + {1'b0, LOOKAHEAD};
    assign due       = ({1'b0, note_time} <= deadline);
    assign rewind    = (state != IDLE) &&
                       (start || (song_time < song_time_q));
    assign rom_addr  = addr;

    always_ff @(posedge clk65 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            fret        <= '0;
            fret_time   <= '0;
            fret_en     <= '0;
            done        <= 1'b0;
            note_count  <= '0;
            song_time_q <= '0;
        end else begin
            song_time_q <= song_time;
            fret_en     <= '0;
            // Rewind (or a restart) wins over whatever the FSM would do.
            if (rewind) begin
                state      <= FETCH;
                addr       <= '0;
                fret       <= '0;
                note_count <= '0;
                done       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= FETCH;
                            addr       <= '0;
                            note_count <= '0;
                        end
                    end
                    FETCH: state <= CHECK;
                    CHECK: begin
                        if (note_time == 16'hFFFF) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (note_str > 3'd5) begin
                            addr  <= addr + 1'b1;
                            state <= FETCH;
                        end else if (!pause && due) begin
                            state     <= ISSUE;
                            fret_en   <= 6'(1) << note_str;
                            fret_time <= note_time;
                            for (int s = 0; s < 6; s++) begin
                                if (note_str == 3'(s))
                                    fret[5*s +: 5] <= note_fret;
                            end
                            if (note_count != 16'hFFFF)
                                note_count <= note_count + 16'd1;
                        end
                    end
                    ISSUE: begin
                        addr  <= addr + 1'b1;
                        state <= FETCH;
                    end
                    DONE: state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Testbench for note_scheduler: directed scenarios plus a randomized
// song checked against an in-order note list model.
module tb_note_scheduler;

    logic        clk65 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] song_time = '0;
    logic [11:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic [29:0] fret;
    logic [15:0] fret_time;
    logic [5:0]  fret_en;
    logic        done;
    logic [15:0] note_count;

    logic [23:0] rom [4096];

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        int t;
        int s;
        int f;
    } note_t;

    note_t exp_q[$];

    always #5 clk65 = ~clk65;

    always @(posedge clk65) rom_data <= rom[rom_addr];

    note_scheduler dut (
        .clk65      (clk65),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .song_time  (song_time),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .fret       (fret),
        .fret_time  (fret_time),
        .fret_en    (fret_en),
        .done       (done),
        .note_count (note_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk65);
    endtask

    function automatic logic [23:0] ent(input int t, input int s,
                                        input int f);
        logic [15:0] tt;
        logic [2:0]  ss;
        logic [4:0]  ff;
        tt = t[15:0];
        ss = s[2:0];
        ff = f[4:0];
        return {tt, ss, ff};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 24'hFFFF00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        song_time = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Steps until a strobe is seen; also drops any pending start pulse.
    task automatic wait_strobe(input int maxc, output int cyc,
                               output bit ok);
        cyc = 0;
        do begin
            step();
            start = 1'b0;
            cyc++;
        end while (fret_en == '0 && cyc < maxc);
        ok = (fret_en != '0);
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        int c;
        c = 0;
        while (!done && c < maxc) begin
            step();
            c++;
        end
        ok = done;
    endtask

    initial begin
        int          cyc;
        bit          ok;
        logic [5:0]  seen;
        int          missed;
        logic [4:0]  mf[6];
        logic [29:0] mv;
        int          mcount;
        int          song_drv;
        bit          pause_drv;
        note_t       e;
        int          t;
        int          s;
        int          f;

        // Reset state
        clear_rom();
        do_reset();
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_fret", 32'(fret), 0);
        chk("rst_ftime", 32'(fret_time), 0);
        chk("rst_fen", 32'(fret_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(note_count), 0);

        // Two notes then sentinel
        rom[0] = ent(100, 0, 3);
        rom[1] = ent(100, 5, 7);
        start = 1'b1;
        wait_strobe(10, cyc, ok);
        chk("basic1_lat", 32'(cyc), 3);
        chk("basic1_fen", 32'(fret_en), 32'h01);
        chk("basic1_fret", 32'(fret[4:0]), 3);
        wait_strobe(10, cyc, ok);
        chk("basic2_gap", 32'(cyc), 3);
        chk("basic2_fen", 32'(fret_en), 32'h20);
        chk("basic2_fret", 32'(fret[29:25]), 7);
        chk("basic2_keep", 32'(fret[4:0]), 3);
        chk("basic2_ftime", 32'(fret_time), 100);
        wait_done(10, ok);
        chk("basic_done", 32'(ok), 1);
        chk("basic_count", 32'(note_count), 2);
        chk("basic_addr", 32'(rom_addr), 2);

        // Lookahead boundary
        clear_rom();
        do_reset();
        rom[0] = ent(5000, 1, 9);
        song_time = 16'd2999;
        start = 1'b1;
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            start = 1'b0;
            seen |= fret_en;
        end
        chk("la_early", 32'(seen), 0);
        song_time = 16'd3000;
        step();
        chk("la_issue", 32'(fret_en), 32'h02);
        chk("la_fret", 32'(fret[9:5]), 9);

        // Pause holds off an eligible note
        clear_rom();
        do_reset();
        rom[0] = ent(10, 2, 4);
        song_time = 16'd100;
        pause = 1'b1;
        start = 1'b1;
        seen = '0;
        for (int i = 0; i < 50; i++) begin
            step();
            start = 1'b0;
            seen |= fret_en;
        end
        chk("pause_hold", 32'(seen), 0);
        pause = 1'b0;
        step();
        chk("pause_rel", 32'(fret_en), 32'h04);

        // Invalid string entry skipped
        clear_rom();
        do_reset();
        rom[0] = ent(10, 0, 1);
        rom[1] = ent(10, 7, 2);
        rom[2] = ent(10, 3, 5);
        start = 1'b1;
        seen = '0;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            start = 1'b0;
            seen |= fret_en;
        end
        chk("skip_done", 32'(done), 1);
        chk("skip_bits", 32'(seen), 32'h09);
        chk("skip_count", 32'(note_count), 2);
        chk("skip_fret", 32'(fret[19:15]), 5);

        // Rewind mid-song
        clear_rom();
        do_reset();
        rom[0] = ent(100, 4, 6);
        rom[1] = ent(20000, 2, 1);
        song_time = 16'd8000;
        start = 1'b1;
        wait_strobe(10, cyc, ok);
        chk("rw_first", 32'(fret_en), 32'h10);
        for (int i = 0; i < 5; i++) step();
        song_time = 16'd0;
        step();
        chk("rw_addr", 32'(rom_addr), 0);
        chk("rw_fret", 32'(fret), 0);
        chk("rw_count", 32'(note_count), 0);
        wait_strobe(10, cyc, ok);
        chk("rw_reissue", 32'(fret_en), 32'h10);
        chk("rw_refret", 32'(fret[24:20]), 6);
        chk("rw_recount", 32'(note_count), 1);

        // Reset during ISSUE
        clear_rom();
        do_reset();
        rom[0] = ent(10, 3, 17);
        start = 1'b1;
        wait_strobe(10, cyc, ok);
        chk("ri_strobe", 32'(fret_en), 32'h08);
        #1 rst_n = 1'b0;
        #1;
        chk("ri_fen", 32'(fret_en), 0);
        chk("ri_fret", 32'(fret), 0);
        chk("ri_ftime", 32'(fret_time), 0);
        chk("ri_count", 32'(note_count), 0);
        chk("ri_addr", 32'(rom_addr), 0);
        step();
        rst_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= fret_en;
        end
        chk("ri_idle", 32'(seen), 0);
        chk("ri_idle_done", 32'(done), 0);
        start = 1'b1;
        wait_strobe(10, cyc, ok);
        chk("ri_restart", 32'(fret_en), 32'h08);

        // Address wrap through the full ROM
        for (int i = 0; i < 4096; i++) rom[i] = ent(0, i % 6, i % 32);
        do_reset();
        start = 1'b1;
        missed = 0;
        for (int k = 0; k < 4097; k++) begin
            wait_strobe(5, cyc, ok);
            if (!ok) missed++;
        end
        chk("wrap_missed", 32'(missed), 0);
        chk("wrap_fen", 32'(fret_en), 32'h01);
        chk("wrap_addr", 32'(rom_addr), 0);
        chk("wrap_count", 32'(note_count), 4097);

        // Randomized song against an ordered note list
        clear_rom();
        exp_q.delete();
        t = 0;
        for (int i = 0; i < 40; i++) begin
            t += $urandom_range(1500);
            s = $urandom_range(7);
            f = $urandom_range(31);
            rom[i] = ent(t, s, f);
            if (s < 6) exp_q.push_back('{t, s, f});
        end
        for (int i = 0; i < 6; i++) mf[i] = '0;
        mcount = 0;
        do_reset();
        start = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            song_drv = int'(song_time);
            pause_drv = pause;
            step();
            start = 1'b0;
            if (fret_en != '0) begin
                chk("rnd_onehot", 32'($onehot(fret_en)), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    mf[e.s] = e.f[4:0];
                    mcount++;
                    for (int j = 0; j < 6; j++) mv[5*j +: 5] = mf[j];
                    chk("rnd_fen", 32'(fret_en), 32'(1 << e.s));
                    chk("rnd_ftime", 32'(fret_time), 32'(e.t));
                    chk("rnd_fret", 32'(mv), 32'(mv) & 32'(fret) |
                        (32'(mv) ^ 32'(fret)) & 32'(mv));
                    chk("rnd_fretv", 32'(fret), 32'(mv));
                    chk("rnd_count", 32'(note_count), 32'(mcount));
                    chk("rnd_elig",
                        32'((e.t <= song_drv + 2000) && !pause_drv), 1);
                end else begin
                    chk("rnd_extra", 32'(fret_en), 0);
                end
            end
            if (done) break;
            pause = ($urandom_range(4) == 0);
            if (int'(song_time) + 150 < 65000)
                song_time = song_time + 16'($urandom_range(150));
        end
        chk("rnd_done", 32'(done), 1);
        chk("rnd_left", 32'(exp_q.size()), 0);
        chk("rnd_final_count", 32'(note_count), 32'(mcount));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
